// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per enabled clock, signed/unsigned,
// start/busy/done handshake, divide-by-zero flag and registered quotient/remainder.
module seq_divider #(
  parameter int unsigned C_NUM_BITS = 8
) (
  input  logic                  CK,
  input  logic                  RN,
  input  logic                  E,
  input  logic                  START,
  input  logic                  SGN,
  input  logic [C_NUM_BITS-1:0] A,
  input  logic [C_NUM_BITS-1:0] B,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  DZ,
  output logic [C_NUM_BITS-1:0] Q,
  output logic [C_NUM_BITS-1:0] R
);

  localparam int unsigned N    = C_NUM_BITS;
  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    rem_q, rem_d;
  logic [N-1:0]    dvd_q, dvd_d;
  logic [N-1:0]    dsr_q, dsr_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            dz_path_q, dz_path_d;
  logic [N-1:0]    q_q, q_d;
  logic [N-1:0]    r_q, r_d;
  logic            done_q, done_d;
  logic            dz_q, dz_d;

  logic [N:0]      shifted;
  logic [N:0]      sub;

  // Partial remainder stays below the divisor, so the N+1-bit difference never overflows
  // and its top bit is the restore decision.
  assign shifted = {rem_q, dvd_q[N-1]};
  assign sub     = shifted - {1'b0, dsr_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dsr_d     = dsr_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    dz_path_d = dz_path_q;
    q_d       = q_q;
    r_d       = r_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          dvd_d     = (SGN && A[N-1]) ? -A : A;
          dsr_d     = (SGN && B[N-1]) ? -B : B;
          q_neg_d   = SGN && (A[N-1] ^ B[N-1]);
          r_neg_d   = SGN && A[N-1];
          rem_d     = '0;
          dz_path_d = (B == '0);
          cnt_d     = CntW'(N - 1);
          state_d   = (B == '0) ? StFix : StCalc;
        end
      end
      StCalc: begin
        if (!sub[N]) begin
          rem_d = sub[N-1:0];
          dvd_d = {dvd_q[N-2:0], 1'b1};
        end else begin
          rem_d = shifted[N-1:0];
          dvd_d = {dvd_q[N-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        // On divide by zero the untouched |A| is still in the dividend register.
        if (dz_path_q) begin
          q_d  = '1;
          r_d  = r_neg_q ? -dvd_q : dvd_q;
          dz_d = 1'b1;
        end else begin
          q_d  = q_neg_q ? -dvd_q : dvd_q;
          r_d  = r_neg_q ? -rem_q : rem_q;
          dz_d = 1'b0;
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      dz_path_q <= 1'b0;
      q_q       <= '0;
      r_q       <= '0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else if (E) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dsr_q     <= dsr_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      dz_path_q <= dz_path_d;
      q_q       <= q_d;
      r_q       <= r_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign BUSY = (state_q != StIdle);
  assign DONE = done_q;
  assign DZ   = dz_q;
  assign Q    = q_q;
  assign R    = r_q;

endmodule
